// File: rtl/alu_mux_pkg.sv
// rtl/alu_mux_pkg.sv - shared constants for the N:1 pipelined operand selector
//
// Purpose : mode encodings and the default datapath geometry used by
//           alu_mux_nto1_pipe and alu_rr_arbiter.
// Ports   : none (package).
// Config  : ALU_MUX_RR_EN enables the round-robin mode in the users of this package.

package alu_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int ALU_MUX_WIDTH = 32;
   localparam int ALU_MUX_N     = 4;

endpackage

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - combinational round-robin grant among N requesters
//
// Purpose : picks the first set request scanning ptr+1, ptr+2, ... (mod N).
// Ports   : req         in  N      request vector
//           ptr         in  SEL_W  index of the most recent winner
//           grant       out N      one-hot grant (all zero when no request)
//           grant_idx   out SEL_W  encoded grant index (0 when no request)
//           grant_valid out 1      some request was granted
// Config  : instantiated only when ALU_MUX_RR_EN is defined.

module alu_rr_arbiter
   import alu_mux_pkg::*;
#(
   parameter int N     = ALU_MUX_N,
   parameter int SEL_W = $clog2(ALU_MUX_N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             grant_valid
);

   int               cand;
   logic [SEL_W-1:0] cand_idx;

   // Scan starts one past ptr so the last winner has lowest priority.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 1; k <= N; k++) begin
         cand     = (int'(ptr) + k) % N;
         cand_idx = SEL_W'(cand);
         if (!grant_valid && req[cand_idx]) begin
            grant_valid     = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_mux_nto1_pipe.sv
// rtl/alu_mux_nto1_pipe.sv - N:1 operand selector with registered valid/ready output
//
// Purpose : selects one of N operand channels (by Selector, or round-robin when
//           compiled in) into a single-entry output register.
// Ports   : clk, reset (async, active-high)
//           In_data   in  N*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
//           In_valid  in  N        per-channel valid
//           In_ready  out N        per-channel accept (combinational)
//           Selector  in  SEL_W    channel index in fixed mode
//           Mode      in  1        MODE_FIXED / MODE_RR (only with ALU_MUX_RR_EN)
//           OUT_data  out WIDTH    registered selected data
//           OUT_valid out 1        OUT_data holds a word
//           OUT_ready in  1        downstream accepts OUT_data
//           OUT_src   out SEL_W    channel that produced OUT_data
// Config  : ALU_MUX_RR_EN adds the Mode port and the round-robin pointer.

module alu_mux_nto1_pipe
   import alu_mux_pkg::*;
#(
   parameter  int WIDTH = ALU_MUX_WIDTH,
   parameter  int N     = ALU_MUX_N,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] In_data,
   input  logic [N-1:0]       In_valid,
   output logic [N-1:0]       In_ready,
   input  logic [SEL_W-1:0]   Selector,
`ifdef ALU_MUX_RR_EN
   input  logic               Mode,
`endif
   output logic [WIDTH-1:0]   OUT_data,
   output logic               OUT_valid,
   input  logic               OUT_ready,
   output logic [SEL_W-1:0]   OUT_src
);

   logic             load_en;
   logic             sel_ok;
   logic [N-1:0]     fixed_oh;
   logic [N-1:0]     grant_oh;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_valid;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;

   assign load_en = !OUT_valid || OUT_ready;

   // Out-of-range selector (non-power-of-2 N) grants nothing.
   assign sel_ok   = ({1'b0, Selector} < (SEL_W + 1)'(N));
   assign fixed_oh = sel_ok ? (N'(1) << Selector) : '0;

`ifdef ALU_MUX_RR_EN
   logic [SEL_W-1:0] ptr;
   logic [N-1:0]     rr_oh;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_valid;

   alu_rr_arbiter #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_rr_arbiter (
      .req         (In_valid),
      .ptr         (ptr),
      .grant       (rr_oh),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   always_comb begin
      if (Mode == MODE_RR) begin
         grant_oh    = rr_oh;
         grant_idx   = rr_idx;
         grant_valid = rr_valid;
      end else begin
         grant_oh    = fixed_oh;
         grant_idx   = Selector;
         grant_valid = sel_ok;
      end
   end

   // Pointer only advances on a round-robin transfer; stalls and fixed-mode
   // transfers leave it alone so fairness resumes where it left off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= SEL_W'(N - 1);
      end else if (xfer && Mode == MODE_RR) begin
         ptr <= rr_idx;
      end
   end
`else
   assign grant_oh    = fixed_oh;
   assign grant_idx   = Selector;
   assign grant_valid = sel_ok;
`endif

   // In fixed mode the selected channel sees ready even when it is not valid;
   // a transfer still needs its valid.
   assign In_ready = load_en ? grant_oh : '0;
   assign xfer     = load_en && grant_valid && |(grant_oh & In_valid);

   // AND-OR mux on the one-hot grant keeps every index in range for any N.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_oh[i]) begin
            sel_data = sel_data | In_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         OUT_valid <= 1'b0;
         OUT_data  <= '0;
         OUT_src   <= '0;
      end else if (xfer) begin
         OUT_valid <= 1'b1;
         OUT_data  <= sel_data;
         OUT_src   <= grant_idx;
      end else if (OUT_ready) begin
         OUT_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_mux_nto1_pipe.sv
// tb/tb_alu_mux_nto1_pipe.sv - self-checking bench for alu_mux_nto1_pipe

module tb_alu_mux_nto1_pipe;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SEL_W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [SEL_W-1:0]   selector;
   logic               mode;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SEL_W-1:0]   out_src;

   logic [23:0] d3;
   logic [2:0]  v3;
   logic [2:0]  r3;
   logic [1:0]  s3;
   logic        m3;
   logic [7:0]  od3;
   logic        ov3;
   logic        ordy3;
   logic [1:0]  os3;

   int checks = 0;
   int errors = 0;

   alu_mux_nto1_pipe #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .In_data   (in_data),
      .In_valid  (in_valid),
      .In_ready  (in_ready),
      .Selector  (selector),
`ifdef ALU_MUX_RR_EN
      .Mode      (mode),
`endif
      .OUT_data  (out_data),
      .OUT_valid (out_valid),
      .OUT_ready (out_ready),
      .OUT_src   (out_src)
   );

   alu_mux_nto1_pipe #(.WIDTH(8), .N(3)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .In_data   (d3),
      .In_valid  (v3),
      .In_ready  (r3),
      .Selector  (s3),
`ifdef ALU_MUX_RR_EN
      .Mode      (m3),
`endif
      .OUT_data  (od3),
      .OUT_valid (ov3),
      .OUT_ready (ordy3),
      .OUT_src   (os3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard model of the N=4 instance, evaluated on the falling edge
   // where inputs are stable for the coming rising edge.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] src;
   } word_t;

   word_t            sb[$];
   word_t            m_word;
   logic             m_valid;
   logic [SEL_W-1:0] m_ptr;
   logic             m_load;
   logic             m_rr;
   int               m_g;
   int               m_c;
   logic [N-1:0]     m_rdy;

   always @(negedge clk) begin
      if (reset) begin
         m_valid = 1'b0;
         m_ptr   = SEL_W'(N - 1);
         sb.delete();
      end else begin
`ifdef ALU_MUX_RR_EN
         m_rr = mode;
`else
         m_rr = 1'b0;
`endif
         m_load = !m_valid || out_ready;
         m_g    = -1;
         if (m_rr) begin
            for (int k = 1; k <= N; k++) begin
               m_c = (int'(m_ptr) + k) % N;
               if (m_g < 0 && in_valid[m_c]) m_g = m_c;
            end
         end else begin
            m_g = int'(selector);
         end
         m_rdy = (m_load && m_g >= 0) ? (N'(1) << m_g) : '0;
         check("sb_in_ready", 64'(in_ready), 64'(m_rdy));
         check("sb_out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: output consumed with empty scoreboard at %0t", $time);
            end else begin
               m_word = sb.pop_front();
               check("sb_out_data", 64'(out_data), 64'(m_word.data));
               check("sb_out_src", 64'(out_src), 64'(m_word.src));
            end
         end
         if (m_load && m_g >= 0 && in_valid[m_g]) begin
            sb.push_back({in_data[m_g*WIDTH +: WIDTH], SEL_W'(m_g)});
            m_valid = 1'b1;
            if (m_rr) m_ptr = SEL_W'(m_g);
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   typedef struct {
      logic [SEL_W-1:0] sel;
      logic [N-1:0]     valid;
      logic [N-1:0]     exp_ready;
      logic             exp_valid;
      logic [WIDTH-1:0] exp_data;
      logic [SEL_W-1:0] exp_src;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{2'd2, 4'b1111, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2};
      vecs[1] = '{2'd1, 4'b0010, 4'b0010, 1'b1, 32'h0000_1234, 2'd1};
      vecs[2] = '{2'd3, 4'b0111, 4'b1000, 1'b0, 32'h0000_1234, 2'd1};
      vecs[3] = '{2'd0, 4'b0001, 4'b0001, 1'b1, 32'h1111_0000, 2'd0};
      vecs[4] = '{2'd3, 4'b1000, 4'b1000, 1'b1, 32'hCAFE_F00D, 2'd3};

      reset     = 1'b1;
      in_data   = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1111_0000};
      in_valid  = '0;
      selector  = '0;
      mode      = 1'b0;
      out_ready = 1'b1;
      d3        = {8'hC3, 8'hB2, 8'hA1};
      v3        = '0;
      s3        = '0;
      m3        = 1'b0;
      ordy3     = 1'b1;
      step();
      step();
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);
      check("reset_out_src", 64'(out_src), 64'd0);
      reset = 1'b0;

      // Fixed-mode vectors, one word per cycle with the sink always ready.
      for (int i = 0; i < 5; i++) begin
         step();
         selector = vecs[i].sel;
         in_valid = vecs[i].valid;
         #1;
         check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
         step();
         in_valid = '0;
         check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
         check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
         check($sformatf("vec%0d_out_src", i), 64'(out_src), 64'(vecs[i].exp_src));
      end

      // Backpressure: word held for 3 cycles, then replaced on the drain edge.
      selector = 2'd2;
      in_valid = 4'b0100;
      step();
      out_ready = 1'b0;
      selector  = 2'd1;
      in_valid  = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_in_ready", 64'(in_ready), 64'd0);
         step();
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_out_data", 64'(out_data), 64'hDEAD_BEEF);
      end
      out_ready = 1'b1;
      in_valid  = 4'b0010;
      #1;
      check("release_in_ready", 64'(in_ready), 64'b0010);
      step();
      in_valid = '0;
      check("release_out_valid", 64'(out_valid), 64'd1);
      check("release_out_data", 64'(out_data), 64'h0000_1234);
      check("release_out_src", 64'(out_src), 64'd1);
      step();
      check("drain_out_valid", 64'(out_valid), 64'd0);
      check("drain_out_data_hold", 64'(out_data), 64'h0000_1234);

      // Asynchronous reset while a word is held.
      selector  = 2'd3;
      in_valid  = 4'b1000;
      out_ready = 1'b0;
      step();
      in_valid = '0;
      check("pre_reset_out_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      #1;
      check("async_reset_out_valid", 64'(out_valid), 64'd0);
      check("async_reset_out_data", 64'(out_data), 64'd0);
      check("async_reset_out_src", 64'(out_src), 64'd0);
      step();
      reset     = 1'b0;
      out_ready = 1'b1;

`ifdef ALU_MUX_RR_EN
      // Round-robin: all valid -> 0,1,2,3,0 then channels 1,3 -> 1,3,1,3.
      mode     = 1'b1;
      in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("rr_all_src%0d", i), 64'(out_src), 64'(i % 4));
      end
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("rr_13_src%0d", i), 64'(out_src), (i % 2 == 0) ? 64'd1 : 64'd3);
      end
      // ptr now 3: grants 0,1,2, stall on 2, next grant must be 3.
      in_valid = 4'b1111;
      for (int i = 0; i < 3; i++) step();
      check("rr_pre_stall_src", 64'(out_src), 64'd2);
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("rr_stall_in_ready", 64'(in_ready), 64'd0);
         step();
         check("rr_stall_src", 64'(out_src), 64'd2);
      end
      out_ready = 1'b1;
      #1;
      check("rr_resume_in_ready", 64'(in_ready), 64'b1000);
      step();
      check("rr_resume_src", 64'(out_src), 64'd3);
      in_valid = '0;
      mode     = 1'b0;
      step();
`endif

      // N=3 instance: Selector = 3 grants nothing.
      s3 = 2'd3;
      v3 = 3'b111;
      #1;
      check("n3_sel3_in_ready", 64'(r3), 64'd0);
      step();
      check("n3_sel3_out_valid", 64'(ov3), 64'd0);
      step();
      check("n3_sel3_out_valid2", 64'(ov3), 64'd0);
      s3 = 2'd2;
      #1;
      check("n3_sel2_in_ready", 64'(r3), 64'b100);
      step();
      v3 = '0;
      check("n3_sel2_out_valid", 64'(ov3), 64'd1);
      check("n3_sel2_out_data", 64'(od3), 64'hC3);
      check("n3_sel2_out_src", 64'(os3), 64'd2);
      step();
      step();

      check("sb_empty_at_end", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
